// File: rtl/ysyx_22051013_ifu_fq_if.sv
// Fetch-unit bus: redirect sources, BPU prediction, instruction memory port and ID-stage output stream.
interface ysyx_22051013_ifu_fq_if #(
  parameter int PC_W      = 64,
  parameter int INST_W    = 32,
  parameter int NUM_REDIR = 3
);
  logic [NUM_REDIR-1:0]      redir_valid;
  logic [NUM_REDIR*PC_W-1:0] redir_pc;
  logic [PC_W-1:0]           bpu_pc;
  logic [PC_W-1:0]           fetch_pc;
  logic                      req_valid;
  logic                      req_ready;
  logic                      rsp_valid;
  logic [INST_W-1:0]         rsp_inst;
  logic                      out_valid;
  logic                      out_ready;
  logic [INST_W-1:0]         out_inst;
  logic [PC_W-1:0]           out_pc;
  logic                      flushing;

  modport master (
    output redir_valid, redir_pc, bpu_pc, req_ready, rsp_valid, rsp_inst, out_ready,
    input  fetch_pc, req_valid, out_valid, out_inst, out_pc, flushing
  );

  modport slave (
    input  redir_valid, redir_pc, bpu_pc, req_ready, rsp_valid, rsp_inst, out_ready,
    output fetch_pc, req_valid, out_valid, out_inst, out_pc, flushing
  );
endinterface

// File: rtl/ysyx_22051013_ifu_fq.sv
// Fetch unit: owns the fetch PC, arbitrates prioritised redirects over the BPU, and buffers
// in-order instruction responses in a small queue; redirects flush it and drop stale responses.
module ysyx_22051013_ifu_fq #(
  parameter int          PC_W      = 64,
  parameter int          INST_W    = 32,
  parameter int          DEPTH     = 4,
  parameter int          NUM_REDIR = 3,
  parameter logic [63:0] RESET_PC  = 64'h8000_0000
) (
  input logic                   clk,
  input logic                   rst_n,
  ysyx_22051013_ifu_fq_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [PW-1:0]     r_alloc, r_fill, r_head, r_stale;
  logic [PC_W-1:0]   r_fetch_pc;
  logic              r_active;
  logic [DEPTH-1:0]  r_filled;
  logic [PC_W-1:0]   r_pc   [DEPTH];
  logic [INST_W-1:0] r_inst [DEPTH];

  logic            w_any_redir, w_full, w_flushing, w_unfilled;
  logic            w_req_valid, w_req_fire, w_fill, w_deq, w_rsp_used;
  logic [PC_W-1:0] w_sel_pc;
  logic [PW-1:0]   w_outstanding, w_rsp_dec;
  logic [AW-1:0]   w_alloc_idx, w_fill_idx, w_head_idx;

  // Scan from the lowest priority upward so the lowest set index wins.
  always_comb begin
    w_sel_pc = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (bus.redir_valid[i]) w_sel_pc = bus.redir_pc[i*PC_W +: PC_W];
    end
  end

  assign w_any_redir   = |bus.redir_valid;
  assign w_alloc_idx   = r_alloc[AW-1:0];
  assign w_fill_idx    = r_fill[AW-1:0];
  assign w_head_idx    = r_head[AW-1:0];
  assign w_full        = (r_alloc - r_head) == DEPTH_P;
  assign w_flushing    = r_stale != '0;
  assign w_unfilled    = r_alloc != r_fill;
  assign w_outstanding = r_alloc - r_fill;

  // r_active keeps requests off during reset and for the first edge after release.
  assign w_req_valid = r_active & ~w_full & ~w_any_redir & ~w_flushing;
  assign w_req_fire  = w_req_valid & bus.req_ready;
  assign w_fill      = bus.rsp_valid & ~w_flushing & w_unfilled & ~w_any_redir;
  assign w_deq       = bus.out_valid & bus.out_ready;
  assign w_rsp_used  = bus.rsp_valid & (w_flushing | w_unfilled);
  assign w_rsp_dec   = w_rsp_used ? PW'(1) : '0;

  assign bus.fetch_pc  = r_fetch_pc;
  assign bus.req_valid = w_req_valid;
  assign bus.out_valid = r_filled[w_head_idx] & ~w_any_redir;
  assign bus.out_inst  = r_inst[w_head_idx];
  assign bus.out_pc    = r_pc[w_head_idx];
  assign bus.flushing  = w_flushing;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC[PC_W-1:0];
      r_active   <= 1'b0;
      r_alloc    <= '0;
      r_fill     <= '0;
      r_head     <= '0;
      r_stale    <= '0;
    end else begin
      r_active <= 1'b1;
      if (w_any_redir) begin
        r_fetch_pc <= w_sel_pc;
        r_alloc    <= r_head;
        r_fill     <= r_head;
        r_stale    <= r_stale + w_outstanding - w_rsp_dec;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= bus.bpu_pc;
          r_alloc    <= r_alloc + PW'(1);
        end
        if (w_fill) r_fill <= r_fill + PW'(1);
        if (w_deq) r_head <= r_head + PW'(1);
        if (bus.rsp_valid && w_flushing) r_stale <= r_stale - PW'(1);
      end
    end
  end

  // Slot indices of alloc, fill and dequeue never coincide in one cycle, so the writes are independent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filled <= '0;
    end else if (w_any_redir) begin
      r_filled <= '0;
    end else begin
      if (w_req_fire) r_filled[w_alloc_idx] <= 1'b0;
      if (w_fill) r_filled[w_fill_idx] <= 1'b1;
      if (w_deq) r_filled[w_head_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire && !w_any_redir) r_pc[w_alloc_idx] <= r_fetch_pc;
    if (w_fill) r_inst[w_fill_idx] <= bus.rsp_inst;
  end
endmodule

// File: tb/tb_ysyx_22051013_ifu_fq.sv
// Directed bench for the fetch unit: reset, streaming, full queue, redirect priority, stale drop, async reset.
module tb_ysyx_22051013_ifu_fq;
  localparam int PC_W = 64;
  localparam int INST_W = 32;
  localparam int NUM_REDIR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n_acc = 0;
  bit   auto_rsp = 1'b0;
  logic [PC_W-1:0] pend[$];

  ysyx_22051013_ifu_fq_if #(.PC_W(PC_W), .INST_W(INST_W), .NUM_REDIR(NUM_REDIR)) bif ();

  ysyx_22051013_ifu_fq #(.PC_W(PC_W), .INST_W(INST_W), .DEPTH(4), .NUM_REDIR(NUM_REDIR),
                         .RESET_PC(64'h8000_0000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  always #5 clk = ~clk;
  assign bif.bpu_pc = bif.fetch_pc + 64'd4;

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: note accepted requests, cross the edge, then let the memory model answer.
  task automatic tick();
    #1;
    if (bif.req_valid && bif.req_ready) begin
      pend.push_back(bif.fetch_pc);
      n_acc++;
    end
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      if (pend.size() > 0) begin
        bif.rsp_valid = 1'b1;
        bif.rsp_inst  = inst_of(pend.pop_front());
      end else begin
        bif.rsp_valid = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    bif.redir_valid = '0;
    bif.redir_pc    = '0;
    bif.req_ready   = 1'b0;
    bif.rsp_valid   = 1'b0;
    bif.rsp_inst    = '0;
    bif.out_ready   = 1'b0;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_fetch_pc", bif.fetch_pc, 64'h8000_0000);
    check("rst_req_valid", 64'(bif.req_valid), 64'd0);
    check("rst_out_valid", 64'(bif.out_valid), 64'd0);
    check("rst_flushing", 64'(bif.flushing), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_req_valid_same", 64'(bif.req_valid), 64'd0);
    @(posedge clk);
    #1;
    check("rel_req_valid_next", 64'(bif.req_valid), 64'd1);

    // Streaming with one-cycle memory
    bif.req_ready = 1'b1;
    bif.out_ready = 1'b1;
    auto_rsp = 1'b1;
    tick();
    check("stream_latency", 64'(bif.out_valid), 64'd0);
    tick();
    check("stream_v0", 64'(bif.out_valid), 64'd1);
    check("stream_pc0", bif.out_pc, 64'h8000_0000);
    check("stream_inst0", 64'(bif.out_inst), 64'(inst_of(64'h8000_0000)));
    tick();
    check("stream_pc1", bif.out_pc, 64'h8000_0004);
    tick();
    check("stream_pc2", bif.out_pc, 64'h8000_0008);
    check("stream_inst2", 64'(bif.out_inst), 64'(inst_of(64'h8000_0008)));
    bif.req_ready = 1'b0;
    tick();
    check("stream_pc3", bif.out_pc, 64'h8000_000C);
    tick();
    check("stream_drained", 64'(bif.out_valid), 64'd0);

    // Full queue: exactly DEPTH accepts, then one per dequeue
    bif.out_ready = 1'b0;
    bif.req_ready = 1'b1;
    n_acc = 0;
    repeat (8) tick();
    check("full_accepts", 64'(n_acc), 64'd4);
    check("full_req_valid", 64'(bif.req_valid), 64'd0);
    check("full_head_pc", bif.out_pc, 64'h8000_0010);
    bif.out_ready = 1'b1;
    tick();
    bif.out_ready = 1'b0;
    n_acc = 0;
    repeat (6) tick();
    check("refill_accepts", 64'(n_acc), 64'd1);
    check("refill_req_valid", 64'(bif.req_valid), 64'd0);
    check("refill_head_pc", bif.out_pc, 64'h8000_0014);

    // Redirect priority: sources 1 and 2 active, source 1 wins
    bif.req_ready = 1'b0;
    bif.redir_valid = 3'b110;
    bif.redir_pc = {64'h300, 64'h200, 64'h100};
    #1;
    check("redir_req_gated", 64'(bif.req_valid), 64'd0);
    check("redir_out_gated", 64'(bif.out_valid), 64'd0);
    tick();
    bif.redir_valid = '0;
    #1;
    check("redir_fetch_pc", bif.fetch_pc, 64'h200);
    check("redir_empty", 64'(bif.out_valid), 64'd0);
    check("redir_no_flush", 64'(bif.flushing), 64'd0);
    check("redir_req_resume", 64'(bif.req_valid), 64'd1);

    // Stale drop: three in flight, redirect, three responses discarded
    auto_rsp = 1'b0;
    bif.rsp_valid = 1'b0;
    pend.delete();
    bif.out_ready = 1'b1;
    bif.req_ready = 1'b1;
    repeat (3) tick();
    check("stale_fetch_pc", bif.fetch_pc, 64'h20C);
    bif.req_ready = 1'b0;
    bif.redir_valid = 3'b001;
    bif.redir_pc = {64'h0, 64'h0, 64'h1000};
    tick();
    bif.redir_valid = '0;
    #1;
    check("stale_redir_pc", bif.fetch_pc, 64'h1000);
    check("stale_flushing", 64'(bif.flushing), 64'd1);
    check("stale_req_block", 64'(bif.req_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      bif.rsp_valid = 1'b1;
      bif.rsp_inst = 32'hDEAD_0000 + 32'(i);
      tick();
      check($sformatf("stale_flush_%0d", i), 64'(bif.flushing), (i < 2) ? 64'd1 : 64'd0);
      check($sformatf("stale_noout_%0d", i), 64'(bif.out_valid), 64'd0);
    end
    bif.rsp_valid = 1'b0;
    #1;
    check("stale_req_resume", 64'(bif.req_valid), 64'd1);
    bif.req_ready = 1'b1;
    tick();
    bif.req_ready = 1'b0;
    bif.out_ready = 1'b0;
    bif.rsp_valid = 1'b1;
    bif.rsp_inst = 32'hCAFE_0004;
    tick();
    bif.rsp_valid = 1'b0;
    #1;
    check("stale_first_valid", 64'(bif.out_valid), 64'd1);
    check("stale_first_pc", bif.out_pc, 64'h1000);
    check("stale_first_inst", 64'(bif.out_inst), 64'hCAFE_0004);

    // Async reset with two queued entries
    bif.req_ready = 1'b1;
    tick();
    bif.req_ready = 1'b0;
    bif.rsp_valid = 1'b1;
    bif.rsp_inst = 32'hCAFE_0005;
    tick();
    bif.rsp_valid = 1'b0;
    #1;
    check("pre_rst_valid", 64'(bif.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bif.out_valid), 64'd0);
    check("arst_fetch_pc", bif.fetch_pc, 64'h8000_0000);
    check("arst_req_valid", 64'(bif.req_valid), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_out_valid", 64'(bif.out_valid), 64'd0);
    check("post_rst_req_valid", 64'(bif.req_valid), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
